// File: rtl/sdram_read.sv
// SDRAM read engine: requests the shared command bus, issues ACT/READ/PRE, captures dq into the read FIFO.
// Define SDRAM_READ_CNT_EN to add the rd_word_cnt port (running count of FIFO write strobes).
module sdram_read #(
   parameter int unsigned CAS_LAT    = 2,
   parameter int unsigned BURST_LEN  = 4,
   parameter int unsigned NUM_BURSTS = 4,
   parameter int unsigned T_RCD      = 2,
   parameter int unsigned T_RP       = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_trig,
   input  logic [1:0]  rd_bank,
   input  logic [11:0] rd_row,
   output logic        r_req,
   input  logic        r_en,
   input  logic        ref_req,
   output logic [17:0] r_cmd,
   input  logic [15:0] dq,
   output logic        rfifo_wr_en,
   output logic [15:0] rfifo_wr_data,
   output logic        read_data_end,
   output logic        read_ref_break_end
`ifdef SDRAM_READ_CNT_EN
   ,
   output logic [15:0] rd_word_cnt
`endif
);

   localparam int unsigned SLOT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned WAIT_W = 8;
   localparam int unsigned BCNT_W = 8;
   localparam int unsigned COL_W  = 9;

   localparam logic [17:0] CMD_IDLE = 18'h3C000;
   localparam logic [17:0] CMD_NOP  = {4'b0111, 14'd0};
   localparam logic [3:0]  OP_ACT   = 4'b0011;
   localparam logic [3:0]  OP_READ  = 4'b0101;
   localparam logic [3:0]  OP_PRE   = 4'b0010;

   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BURST_LEN - 1);
   localparam logic [WAIT_W-1:0] TRCD_LAST = WAIT_W'(T_RCD - 1);
   localparam logic [WAIT_W-1:0] TRP_LAST  = WAIT_W'(T_RP - 1);
   localparam logic [BCNT_W-1:0] BURSTS    = BCNT_W'(NUM_BURSTS);
   localparam logic [COL_W-1:0]  COL_STEP  = COL_W'(BURST_LEN);

   typedef enum logic [2:0] {
      R_IDLE, R_REQ, R_ACT, R_TRCD, R_RD, R_PRE, R_TRP
   } state_t;

   state_t              state;
   logic [1:0]          bank;
   logic [11:0]         row;
   logic [COL_W-1:0]    col;
   logic [SLOT_W-1:0]   slot_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [BCNT_W-1:0]   burst_cnt;
   logic                done;

   logic [CAS_LAT-1:0]  rd_pipe;
   logic [SLOT_W-1:0]   cap_left;

   logic                slot_first_c;
   logic                last_burst_c;
   logic [COL_W-1:0]    col_next_c;
   logic                cap_idle_c;
   logic                is_read_c;

   // Column/burst count including a READ issued in the current cycle (matters when BURST_LEN is 1)
   assign slot_first_c = (slot_cnt == '0);
   assign col_next_c   = slot_first_c ? col + COL_STEP : col;
   assign last_burst_c = (burst_cnt + BCNT_W'(slot_first_c)) == BURSTS;
   assign cap_idle_c   = (rd_pipe == '0) && (cap_left == '0);
   assign is_read_c    = (r_cmd[17:14] == OP_READ);

   // Command sequencer; r_cmd is loaded with the command of the state being entered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= R_IDLE;
         r_req              <= 1'b0;
         r_cmd              <= CMD_IDLE;
         read_data_end      <= 1'b0;
         read_ref_break_end <= 1'b0;
         bank               <= '0;
         row                <= '0;
         col                <= '0;
         slot_cnt           <= '0;
         wait_cnt           <= '0;
         burst_cnt          <= '0;
         done               <= 1'b0;
      end else begin
         read_data_end      <= 1'b0;
         read_ref_break_end <= 1'b0;
         case (state)
            R_IDLE: begin
               if (rd_trig) begin
                  bank      <= rd_bank;
                  row       <= rd_row;
                  col       <= '0;
                  burst_cnt <= '0;
                  r_req     <= 1'b1;
                  state     <= R_REQ;
               end
            end
            R_REQ: begin
               if (r_en) begin
                  r_cmd <= {OP_ACT, bank, row};
                  state <= R_ACT;
               end
            end
            R_ACT: begin
               r_cmd    <= CMD_NOP;
               wait_cnt <= '0;
               state    <= R_TRCD;
            end
            R_TRCD: begin
               if (wait_cnt == TRCD_LAST) begin
                  r_cmd    <= {OP_READ, bank, 3'b000, col};
                  slot_cnt <= '0;
                  state    <= R_RD;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            R_RD: begin
               if (slot_first_c) begin
                  col       <= col + COL_STEP;
                  burst_cnt <= burst_cnt + BCNT_W'(1);
               end
               // Refresh is only honoured at a slot boundary so a burst is never cut short
               if (slot_cnt == SLOT_LAST) begin
                  slot_cnt <= '0;
                  if (last_burst_c || ref_req) begin
                     done  <= last_burst_c;
                     r_cmd <= {OP_PRE, bank, 12'h400};
                     state <= R_PRE;
                  end else begin
                     r_cmd <= {OP_READ, bank, 3'b000, col_next_c};
                  end
               end else begin
                  slot_cnt <= slot_cnt + SLOT_W'(1);
                  r_cmd    <= CMD_NOP;
               end
            end
            R_PRE: begin
               r_cmd    <= CMD_NOP;
               wait_cnt <= '0;
               state    <= R_TRP;
            end
            R_TRP: begin
               if (wait_cnt >= TRP_LAST) begin
                  if (cap_idle_c) begin
                     r_cmd <= CMD_IDLE;
                     if (done) begin
                        read_data_end <= 1'b1;
                        r_req         <= 1'b0;
                        state         <= R_IDLE;
                     end else begin
                        read_ref_break_end <= 1'b1;
                        state              <= R_REQ;
                     end
                  end
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            default: begin
               r_cmd <= CMD_IDLE;
               r_req <= 1'b0;
               state <= R_IDLE;
            end
         endcase
      end
   end

   // Capture pipeline: each READ on r_cmd yields BURST_LEN words CAS_LAT cycles later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pipe       <= '0;
         cap_left      <= '0;
         rfifo_wr_en   <= 1'b0;
         rfifo_wr_data <= '0;
`ifdef SDRAM_READ_CNT_EN
         rd_word_cnt   <= '0;
`endif
      end else begin
         rd_pipe <= (rd_pipe << 1) | CAS_LAT'(is_read_c);
         if (rd_pipe[CAS_LAT-1] || (cap_left != '0)) begin
            rfifo_wr_en   <= 1'b1;
            rfifo_wr_data <= dq;
            cap_left      <= rd_pipe[CAS_LAT-1] ? SLOT_LAST : cap_left - SLOT_W'(1);
`ifdef SDRAM_READ_CNT_EN
            rd_word_cnt   <= rd_word_cnt + 16'd1;
`endif
         end else begin
            rfifo_wr_en <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read: per-cycle model of the FIFO strobe stream plus literal command-log checks.
module tb_sdram_read;

   localparam int unsigned CAS = 2;
   localparam int unsigned BL  = 4;
   localparam int unsigned NB  = 4;

   logic        clk;
   logic        rst;
   logic        rd_trig;
   logic [1:0]  rd_bank;
   logic [11:0] rd_row;
   logic        r_req;
   logic        r_en;
   logic        ref_req;
   logic [17:0] r_cmd;
   logic [15:0] dq;
   logic        rfifo_wr_en;
   logic [15:0] rfifo_wr_data;
   logic        read_data_end;
   logic        read_ref_break_end;
`ifdef SDRAM_READ_CNT_EN
   logic [15:0] rd_word_cnt;
`endif

   sdram_read #(.CAS_LAT(CAS), .BURST_LEN(BL), .NUM_BURSTS(NB), .T_RCD(2), .T_RP(2)) dut (
      .clk(clk), .rst(rst), .rd_trig(rd_trig), .rd_bank(rd_bank), .rd_row(rd_row),
      .r_req(r_req), .r_en(r_en), .ref_req(ref_req), .r_cmd(r_cmd), .dq(dq),
      .rfifo_wr_en(rfifo_wr_en), .rfifo_wr_data(rfifo_wr_data),
      .read_data_end(read_data_end), .read_ref_break_end(read_ref_break_end)
`ifdef SDRAM_READ_CNT_EN
      , .rd_word_cnt(rd_word_cnt)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_words = 0;
   int n_end = 0;
   int n_brk = 0;
   int model_reads = 0;
   logic [1:0]  tr_bank = '0;
   logic [11:0] tr_row = '0;

   typedef struct { int cyc; logic [15:0] data; } exp_t;
   exp_t exp_q[$];
   logic [17:0] cmd_log[$];
   int          cmd_cyc[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] pat(input int c);
      return 16'(c * 945) ^ 16'h5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: dq carries pat(cycle); every READ seen owes BL words, CAS cycles later, one cycle delayed
   initial begin
      dq = '0;
      forever begin
         @(negedge clk);
         cyc++;
         dq = pat(cyc);
         if (rst) begin
            exp_q.delete();
            model_reads = 0;
            chk("rst_wr_en", 32'(rfifo_wr_en), 0);
            chk("rst_cmd", 32'(r_cmd), 32'h3C000);
            chk("rst_req", 32'(r_req), 0);
         end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               chk("wr_en", 32'(rfifo_wr_en), 1);
               chk("wr_data", 32'(rfifo_wr_data), 32'(exp_q[0].data));
               void'(exp_q.pop_front());
            end else begin
               chk("spurious_wr_en", 32'(rfifo_wr_en), 0);
            end
            if (rfifo_wr_en) n_words++;
            if (!r_req) chk("idle_cmd", 32'(r_cmd), 32'h3C000);
            case (r_cmd[17:14])
               4'b0011: begin
                  chk("act_ba", 32'(r_cmd[13:12]), 32'(tr_bank));
                  chk("act_row", 32'(r_cmd[11:0]), 32'(tr_row));
                  cmd_log.push_back(r_cmd); cmd_cyc.push_back(cyc);
               end
               4'b0101: begin
                  chk("read_ba", 32'(r_cmd[13:12]), 32'(tr_bank));
                  chk("read_col", 32'(r_cmd[11:0]), 32'(9'(model_reads * BL)));
                  for (int k = 0; k < BL; k++)
                     exp_q.push_back('{cyc + CAS + 1 + k, pat(cyc + CAS + k)});
                  model_reads++;
                  cmd_log.push_back(r_cmd); cmd_cyc.push_back(cyc);
               end
               4'b0010: begin
                  chk("pre_addr", 32'(r_cmd[11:0]), 32'h400);
                  cmd_log.push_back(r_cmd); cmd_cyc.push_back(cyc);
               end
               default: ;
            endcase
            if (read_data_end) begin
               n_end++;
               chk("end_pending_words", exp_q.size(), 0);
               chk("end_reads", model_reads, NB);
               chk("end_req_low", 32'(r_req), 0);
               model_reads = 0;
            end
            if (read_ref_break_end) begin
               n_brk++;
               chk("brk_pending_words", exp_q.size(), 0);
               chk("brk_req_held", 32'(r_req), 1);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic trigger(input logic [1:0] b, input logic [11:0] r);
      tr_bank = b; tr_row = r;
      rd_bank = b; rd_row = r;
      rd_trig = 1'b1;
      tick();
      rd_trig = 1'b0;
   endtask

   task automatic grant();
      int i;
      for (i = 0; i < 20 && !r_req; i++) tick();
      chk("req_seen", 32'(r_req), 1);
      repeat (2) tick();
      r_en = 1'b1;
      tick();
      r_en = 1'b0;
   endtask

   task automatic wait_pulse(output int kind);
      kind = 0;
      for (int i = 0; i < 300 && kind == 0; i++) begin
         tick();
         if (read_data_end) kind = 1;
         else if (read_ref_break_end) kind = 2;
      end
   endtask

   task automatic wait_read_col(input logic [8:0] c);
      bit found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (r_cmd[17:14] == 4'b0101 && r_cmd[8:0] == c) found = 1;
         else tick();
      end
      chk("read_col_seen", 32'(found), 1);
   endtask

   task automatic chk_log(input string name, input logic [17:0] exp[$]);
      chk({name, "_len"}, cmd_log.size(), exp.size());
      for (int i = 0; i < exp.size() && i < cmd_log.size(); i++)
         chk(name, 32'(cmd_log[i]), 32'(exp[i]));
   endtask

   initial begin
      int kind, w0, e0, b0;
      rst = 1'b1; rd_trig = 1'b0; rd_bank = '0; rd_row = '0; r_en = 1'b0; ref_req = 1'b0;
      repeat (3) tick();
      chk("reset_cmd", 32'(r_cmd), 32'h3C000);
      chk("reset_req", 32'(r_req), 0);
      chk("reset_wr_data", 32'(rfifo_wr_data), 0);
      chk("reset_end", 32'(read_data_end), 0);
      chk("reset_brk", 32'(read_ref_break_end), 0);
      rst = 1'b0;

      // Idle for 100 cycles without a trigger
      w0 = n_words;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("idle_req", 32'(r_req), 0);
      end
      chk("idle_words", n_words - w0, 0);

      // Plain transaction
      cmd_log.delete(); cmd_cyc.delete();
      w0 = n_words; e0 = n_end;
      trigger(2'd1, 12'h012);
      grant();
      wait_pulse(kind);
      chk("t2_kind", kind, 1);
      repeat (3) tick();
      chk("t2_words", n_words - w0, 16);
      chk("t2_ends", n_end - e0, 1);
      chk("t2_req", 32'(r_req), 0);
      chk_log("t2_cmd", '{18'h0D012, 18'h15000, 18'h15004, 18'h15008, 18'h1500C, 18'h09400});
      if (cmd_cyc.size() >= 3) begin
         chk("t2_act_to_read", cmd_cyc[1] - cmd_cyc[0], 3);
         chk("t2_read_spacing", cmd_cyc[2] - cmd_cyc[1], 4);
      end

      // Refresh request during the second burst
      cmd_log.delete(); cmd_cyc.delete();
      w0 = n_words; e0 = n_end; b0 = n_brk;
      trigger(2'd2, 12'h0AB);
      grant();
      wait_read_col(9'd4);
      ref_req = 1'b1;
      wait_pulse(kind);
      chk("t3_kind_brk", kind, 2);
      ref_req = 1'b0;
      chk("t3_req_held", 32'(r_req), 1);
      chk("t3_words_at_brk", n_words - w0, 8);
      grant();
      wait_pulse(kind);
      chk("t3_kind_end", kind, 1);
      repeat (3) tick();
      chk("t3_words", n_words - w0, 16);
      chk("t3_ends", n_end - e0, 1);
      chk("t3_brks", n_brk - b0, 1);
      chk_log("t3_cmd", '{18'h0E0AB, 18'h16000, 18'h16004, 18'h0A400,
                          18'h0E0AB, 18'h16008, 18'h1600C, 18'h0A400});

      // Trigger while busy is dropped
      cmd_log.delete(); cmd_cyc.delete();
      w0 = n_words; e0 = n_end;
      trigger(2'd3, 12'hABC);
      grant();
      wait_read_col(9'd4);
      rd_bank = 2'd0; rd_row = 12'h777; rd_trig = 1'b1;
      tick();
      rd_trig = 1'b0;
      wait_pulse(kind);
      chk("t4_kind", kind, 1);
      repeat (10) tick();
      chk("t4_no_req", 32'(r_req), 0);
      chk("t4_words", n_words - w0, 16);
      chk("t4_ends", n_end - e0, 1);
      chk_log("t4_cmd", '{18'h0FABC, 18'h17000, 18'h17004, 18'h17008, 18'h1700C, 18'h0B400});

      // Asynchronous reset in the middle of the read phase
      trigger(2'd0, 12'h345);
      grant();
      wait_read_col(9'd4);
      chk("t5_wr_en_before", 32'(rfifo_wr_en), 1);
      rst = 1'b1;
      #1;
      chk("t5_req", 32'(r_req), 0);
      chk("t5_cmd", 32'(r_cmd), 32'h3C000);
      chk("t5_wr_en", 32'(rfifo_wr_en), 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      cmd_log.delete(); cmd_cyc.delete();
      w0 = n_words; e0 = n_end;
      trigger(2'd0, 12'h345);
      grant();
      wait_pulse(kind);
      chk("t5_kind", kind, 1);
      repeat (3) tick();
      chk("t5_words", n_words - w0, 16);
      chk("t5_ends", n_end - e0, 1);
      chk_log("t5_cmd", '{18'h0C345, 18'h14000, 18'h14004, 18'h14008, 18'h1400C, 18'h08400});

`ifdef SDRAM_READ_CNT_EN
      // Word counter across two full transactions from reset
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("cnt_reset", 32'(rd_word_cnt), 0);
      for (int t = 0; t < 2; t++) begin
         trigger(2'd1, 12'h100);
         grant();
         wait_pulse(kind);
         chk("cnt_kind", kind, 1);
      end
      repeat (3) tick();
      chk("cnt_total", 32'(rd_word_cnt), 32);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
